// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants for the register/condition-code scoreboard.
package lc3b_types;

    // Scoreboard entry index: 0..7 are R0..R7, 8 is the NZP condition codes.
    typedef logic [3:0] lc3b_sb_idx;

    localparam int SB_CC_IDX  = 8;
    localparam int SB_ENTRIES = 9;

    // One bit per scoreboard entry.
    typedef logic [SB_ENTRIES-1:0] lc3b_sb_vec;

    // Per-entry net change in one cycle: -2..+1.
    typedef logic signed [2:0] lc3b_sb_delta;

    // Combine one increment and two decrements into a single signed delta.
    function automatic lc3b_sb_delta sb_delta(input logic inc, input logic dec_a, input logic dec_b);
        lc3b_sb_delta d;
        d = $signed({2'b00, inc}) - $signed({2'b00, dec_a}) - $signed({2'b00, dec_b});
        return d;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One saturating in-flight counter. Applies a signed delta each cycle,
// clamps to [0, 2**CNT_W-1] and flags any clamp as an overflow/underflow.
module sb_counter
    import lc3b_types::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  lc3b_sb_delta     delta,
    output logic [CNT_W-1:0] cnt,
    output logic             flag
);

    // Two spare bits: one for the +1 headroom, one for the sign.
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] sum;

    // Next count: add the delta, then clamp into range and report any clamp.
    always_comb begin
        delta_ext = SUM_W'(delta);
        sum       = $signed({2'b00, cnt_reg}) + delta_ext;
        cnt_next  = sum[CNT_W-1:0];
        flag      = 1'b0;
        if (sum > CNT_MAX) begin
            cnt_next = CNT_MAX[CNT_W-1:0];
            flag     = 1'b1;
        end else if (sum < 0) begin
            cnt_next = '0;
            flag     = 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// RAW scoreboard for R0..R7 and NZP. Counts in-flight writers per entry from
// issue into EX until WB retirement or squash, and stalls decode while any
// source it reads still has an outstanding writer.
module reg_scoreboard
    import lc3b_types::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       decode_valid,
    input  logic [2:0] sr1,
    input  logic [2:0] sr2,
    input  logic       sr1_used,
    input  logic       sr2_used,
    input  logic       cc_used,
    input  logic [2:0] dr,
    input  logic       dr_used,
    input  logic       sets_cc,
    input  logic       load_ex,
    input  logic       wb_valid,
    input  logic [2:0] wb_dr,
    input  logic       wb_dr_used,
    input  logic       wb_sets_cc,
    input  logic       sq_valid,
    input  logic [2:0] sq_dr,
    input  logic       sq_dr_used,
    input  logic       sq_sets_cc,
    output logic       dep_stall,
    output logic [8:0] busy,
    output logic       sb_error
);

    logic [CNT_W-1:0] cnt [SB_ENTRIES];
    lc3b_sb_vec       busy_vec;
    lc3b_sb_vec       hot;
    lc3b_sb_vec       flag_vec;
    lc3b_sb_vec       issue_hit;
    lc3b_sb_vec       retire_hit;
    lc3b_sb_vec       squash_hit;
    logic             issue;
    logic             sb_error_reg;

    // Hazard check uses pre-issue state, so an instruction never stalls on itself.
    assign dep_stall = decode_valid & ((sr1_used & hot[{1'b0, sr1}])
                                     | (sr2_used & hot[{1'b0, sr2}])
                                     | (cc_used  & hot[SB_CC_IDX]));

    assign issue = decode_valid & load_ex & ~dep_stall;

    genvar gi;
    generate
        for (gi = 0; gi < SB_ENTRIES; gi++) begin : g_entry
            // Which write sets touch this entry (NZP entry keys off the cc flags).
            assign issue_hit[gi]  = (gi == SB_CC_IDX) ? sets_cc
                                  : (dr_used && ({1'b0, dr} == lc3b_sb_idx'(gi)));
            assign retire_hit[gi] = wb_valid & ((gi == SB_CC_IDX) ? wb_sets_cc
                                  : (wb_dr_used && ({1'b0, wb_dr} == lc3b_sb_idx'(gi))));
            assign squash_hit[gi] = sq_valid & ((gi == SB_CC_IDX) ? sq_sets_cc
                                  : (sq_dr_used && ({1'b0, sq_dr} == lc3b_sb_idx'(gi))));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .delta   (sb_delta(issue & issue_hit[gi], retire_hit[gi], squash_hit[gi])),
                .cnt     (cnt[gi]),
                .flag    (flag_vec[gi])
            );

            assign busy_vec[gi] = |cnt[gi];

            // With write-through, the last writer retiring this cycle no longer blocks a reader.
            if (WB_BYPASS) begin : g_bypass
                assign hot[gi] = busy_vec[gi] & ~((cnt[gi] == CNT_W'(1)) & retire_hit[gi]);
            end else begin : g_no_bypass
                assign hot[gi] = busy_vec[gi];
            end
        end
    endgenerate

    // Sticky error: any counter clamp since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_error_reg <= 1'b0;
        end else if (|flag_vec) begin
            sb_error_reg <= 1'b1;
        end
    end

    assign busy     = busy_vec;
    assign sb_error = sb_error_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. The driver pushes the expected outputs of
// each cycle into a queue; a monitor on the falling edge pops and compares.
// Two instances (write-through on and off) see identical stimulus.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       decode_valid, sr1_used, sr2_used, cc_used, dr_used, sets_cc, load_ex;
    logic [2:0] sr1, sr2, dr;
    logic       wb_valid, wb_dr_used, wb_sets_cc;
    logic [2:0] wb_dr;
    logic       sq_valid, sq_dr_used, sq_sets_cc;
    logic [2:0] sq_dr;

    logic       dep_stall, sb_error;
    logic [8:0] busy;
    logic       dep_stall_nb, sb_error_nb;
    logic [8:0] busy_nb;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      nm;
        logic       stall_byp;
        logic       stall_nb;
        logic [8:0] busy;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .decode_valid(decode_valid),
        .sr1(sr1), .sr2(sr2), .sr1_used(sr1_used), .sr2_used(sr2_used), .cc_used(cc_used),
        .dr(dr), .dr_used(dr_used), .sets_cc(sets_cc), .load_ex(load_ex),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_dr_used(wb_dr_used), .wb_sets_cc(wb_sets_cc),
        .sq_valid(sq_valid), .sq_dr(sq_dr), .sq_dr_used(sq_dr_used), .sq_sets_cc(sq_sets_cc),
        .dep_stall(dep_stall), .busy(busy), .sb_error(sb_error)
    );

    reg_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(2)) dut_nb (
        .clk(clk), .reset_n(reset_n), .decode_valid(decode_valid),
        .sr1(sr1), .sr2(sr2), .sr1_used(sr1_used), .sr2_used(sr2_used), .cc_used(cc_used),
        .dr(dr), .dr_used(dr_used), .sets_cc(sets_cc), .load_ex(load_ex),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_dr_used(wb_dr_used), .wb_sets_cc(wb_sets_cc),
        .sq_valid(sq_valid), .sq_dr(sq_dr), .sq_dr_used(sq_dr_used), .sq_sets_cc(sq_sets_cc),
        .dep_stall(dep_stall_nb), .busy(busy_nb), .sb_error(sb_error_nb)
    );

    function automatic void chk(input string nm, input string what, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, what, act, expv);
        end
    endfunction

    function automatic void check_all(input exp_t e);
        $display("txn %-12s stall=%0d/%0d busy=0x%03h/0x%03h err=%0d/%0d",
                 e.nm, dep_stall, dep_stall_nb, busy, busy_nb, sb_error, sb_error_nb);
        chk(e.nm, "stall_byp", int'(dep_stall),    int'(e.stall_byp));
        chk(e.nm, "stall_nb",  int'(dep_stall_nb), int'(e.stall_nb));
        chk(e.nm, "busy_byp",  int'(busy),         int'(e.busy));
        chk(e.nm, "busy_nb",   int'(busy_nb),      int'(e.busy));
        chk(e.nm, "err_byp",   int'(sb_error),     int'(e.err));
        chk(e.nm, "err_nb",    int'(sb_error_nb),  int'(e.err));
    endfunction

    // Monitor: compare everything queued for this cycle, away from the rising edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            check_all(exp_q.pop_front());
        end
    end

    task automatic clear();
        decode_valid = 0; sr1 = 0; sr2 = 0; sr1_used = 0; sr2_used = 0; cc_used = 0;
        dr = 0; dr_used = 0; sets_cc = 0; load_ex = 0;
        wb_valid = 0; wb_dr = 0; wb_dr_used = 0; wb_sets_cc = 0;
        sq_valid = 0; sq_dr = 0; sq_dr_used = 0; sq_sets_cc = 0;
    endtask

    task automatic dec(input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                       input logic cc, input logic [2:0] d, input logic du, input logic scc,
                       input logic ld);
        decode_valid = 1; sr1 = s1; sr1_used = u1; sr2 = s2; sr2_used = u2; cc_used = cc;
        dr = d; dr_used = du; sets_cc = scc; load_ex = ld;
    endtask

    task automatic retire(input logic [2:0] d, input logic du, input logic scc);
        wb_valid = 1; wb_dr = d; wb_dr_used = du; wb_sets_cc = scc;
    endtask

    task automatic squash(input logic [2:0] d, input logic du, input logic scc);
        sq_valid = 1; sq_dr = d; sq_dr_used = du; sq_sets_cc = scc;
    endtask

    // Queue the expected outputs for the inputs now applied, then advance one cycle.
    task automatic cyc(input string nm, input logic s_byp, input logic s_nb,
                       input logic [8:0] b, input logic e);
        exp_t x;
        x.nm = nm; x.stall_byp = s_byp; x.stall_nb = s_nb; x.busy = b; x.err = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        clear();
    endtask

    initial begin
        exp_t z;
        clear();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, with a decode applied that must not stall.
        dec(3'd2, 1, 3'd3, 1, 0, 3'd1, 1, 0, 1);
        cyc("reset", 0, 0, 9'h000, 0);
        reset_n = 1'b1;

        // ADD R1 <- R2,R3 issues; busy[1] visible next cycle.
        dec(3'd2, 1, 3'd3, 1, 0, 3'd1, 1, 0, 1);  cyc("add_r1", 0, 0, 9'h000, 0);
        cyc("busy_r1", 0, 0, 9'h002, 0);
        // ADD R4 <- R1,R1 held in decode (load_ex low keeps both instances in lockstep).
        dec(3'd1, 1, 3'd1, 1, 0, 3'd4, 1, 0, 0);  cyc("raw_r1_a", 1, 1, 9'h002, 0);
        dec(3'd1, 1, 3'd1, 1, 0, 3'd4, 1, 0, 0);  cyc("raw_r1_b", 1, 1, 9'h002, 0);
        dec(3'd1, 1, 3'd1, 1, 0, 3'd4, 1, 0, 0);  retire(3'd1, 1, 0);
        cyc("wb_r1", 0, 1, 9'h002, 0);
        dec(3'd1, 1, 3'd1, 1, 0, 3'd4, 1, 0, 0);  cyc("after_wb_r1", 0, 0, 9'h000, 0);

        // Three writers to R5 saturate the counter; a fourth overflows.
        dec(3'd0, 0, 3'd0, 0, 0, 3'd5, 1, 0, 1);  cyc("r5_iss1", 0, 0, 9'h000, 0);
        dec(3'd0, 0, 3'd0, 0, 0, 3'd5, 1, 0, 1);  cyc("r5_iss2", 0, 0, 9'h020, 0);
        dec(3'd0, 0, 3'd0, 0, 0, 3'd5, 1, 0, 1);  cyc("r5_iss3", 0, 0, 9'h020, 0);
        dec(3'd0, 0, 3'd0, 0, 0, 3'd5, 1, 0, 1);  cyc("r5_iss4", 0, 0, 9'h020, 0);
        // Count held at 3: exactly three retires drain it.
        retire(3'd5, 1, 0);  cyc("r5_ret1", 0, 0, 9'h020, 1);
        retire(3'd5, 1, 0);  cyc("r5_ret2", 0, 0, 9'h020, 1);
        retire(3'd5, 1, 0);  cyc("r5_ret3", 0, 0, 9'h020, 1);
        cyc("r5_empty", 0, 0, 9'h000, 1);

        // Clear the sticky error.
        reset_n = 1'b0;
        cyc("reset2", 0, 0, 9'h000, 0);
        reset_n = 1'b1;

        // CC writer, then BR stalls until the writer is squashed.
        dec(3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1, 1);  cyc("add_cc", 0, 0, 9'h000, 0);
        dec(3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0, 1);  cyc("br_stall", 1, 1, 9'h100, 0);
        dec(3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0, 1);  squash(3'd0, 0, 1);
        cyc("br_squash", 1, 1, 9'h100, 0);
        dec(3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0, 1);  cyc("br_go", 0, 0, 9'h000, 0);

        // Simultaneous issue and retire of R2 nets to zero.
        dec(3'd0, 0, 3'd0, 0, 0, 3'd2, 1, 0, 1);  cyc("r2_iss", 0, 0, 9'h000, 0);
        dec(3'd0, 0, 3'd0, 0, 0, 3'd2, 1, 0, 1);  retire(3'd2, 1, 0);
        cyc("r2_iss_ret", 0, 0, 9'h004, 0);
        cyc("r2_held", 0, 0, 9'h004, 0);
        retire(3'd2, 1, 0);  cyc("r2_ret", 0, 0, 9'h004, 0);
        cyc("r2_empty", 0, 0, 9'h000, 0);

        // Self-dependence: ADD R3 <- R3 never stalls on itself.
        dec(3'd3, 1, 3'd0, 0, 0, 3'd3, 1, 0, 1);  cyc("self_r3", 0, 0, 9'h000, 0);
        dec(3'd3, 1, 3'd0, 0, 0, 3'd6, 1, 0, 0);  cyc("raw_r3", 1, 1, 9'h008, 0);
        dec(3'd3, 1, 3'd0, 0, 0, 3'd6, 1, 0, 0);  retire(3'd3, 1, 0);
        cyc("wb_r3", 0, 1, 9'h008, 0);
        cyc("r3_empty", 0, 0, 9'h000, 0);

        // Underflow: retire R6 with nothing in flight.
        retire(3'd6, 1, 0);  cyc("r6_under", 0, 0, 9'h000, 0);
        cyc("err_sticky", 0, 0, 9'h000, 1);

        // Load up R7, then reset asynchronously in the middle of a cycle.
        dec(3'd0, 0, 3'd0, 0, 0, 3'd7, 1, 0, 1);  cyc("r7_iss", 0, 0, 9'h000, 1);
        dec(3'd7, 1, 3'd0, 0, 0, 3'd1, 1, 0, 0);  cyc("raw_r7", 1, 1, 9'h080, 1);
        dec(3'd7, 1, 3'd0, 0, 0, 3'd1, 1, 0, 0);
        #1;
        reset_n = 1'b0;
        #1;
        z.nm = "async_rst"; z.stall_byp = 0; z.stall_nb = 0; z.busy = 9'h000; z.err = 0;
        check_all(z);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear();
        @(negedge clk);
        #1;
        chk("end", "queue_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register/condition-code scoreboard for the LC-3b pipeline. It sits upstream of the decode stall logic and produces the `dep_stall` that block consumes. It tracks in-flight writes to R0–R7 and the NZP condition codes from issue into EX until retirement in WB, or until squashed by a branch flush. It stalls the instruction in decode while any source it reads has an outstanding writer. The pipeline has no operand forwarding; this block alone guarantees RAW correctness.

## Interface
Parameters:
- `WB_BYPASS`, 1: when 1, the register file writes through on a same-cycle read, so a retiring writer does not stall decode.
- `CNT_W`, 2: per-entry in-flight counter width. Maximum count is 3 (EX, MEM, WB).

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: pipeline clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low; clears all state.
- `decode_valid` in 1: decode holds a real (non-bubble) instruction.
- `sr1`, `sr2` in 3: decode source register indices.
- `sr1_used`, `sr2_used` in 1: the corresponding source is actually read.
- `cc_used` in 1: decode instruction reads NZP (BR).
- `dr` in 3: decode destination register.
- `dr_used` in 1: decode instruction writes `dr` (includes R7 for JSR/TRAP).
- `sets_cc` in 1: decode instruction writes NZP.
- `load_ex` in 1: decode→EX latch loads this cycle.
- `wb_valid` in 1: a real instruction retires in WB this cycle.
- `wb_dr`, `wb_dr_used`, `wb_sets_cc` in 3/1/1: the retiring instruction's write set.
- `sq_valid` in 1: one in-flight instruction is squashed this cycle.
- `sq_dr`, `sq_dr_used`, `sq_sets_cc` in 3/1/1: the squashed instruction's write set.
- `dep_stall` out 1: hazard present; decode must bubble EX.
- `busy` out 9: bits 0–7 are R0–R7; bit 8 is NZP. Bit n is set when counter n is nonzero.
- `sb_error` out 1: sticky error; set on counter overflow or underflow.

## Operation
- State: 9 counters of `CNT_W` bits, indices 0–7 for GPRs and 8 for NZP, plus the `sb_error` flag.
- Hazard: `dep_stall = decode_valid & ((sr1_used & hot[sr1]) | (sr2_used & hot[sr2]) | (cc_used & hot[8]))`.
  - When `WB_BYPASS=1`, `hot[n] = busy[n] & ~(cnt[n]==1 & retiring write to n this cycle)`.
  - When `WB_BYPASS=0`, `hot[n] = busy[n]`.
- Issue: `issue = decode_valid & load_ex & ~dep_stall`.
  - On issue, increment `cnt[dr]` if `dr_used`, and increment `cnt[8]` if `sets_cc`.
- Retire: on `wb_valid`, decrement `cnt[wb_dr]` if `wb_dr_used`, and decrement `cnt[8]` if `wb_sets_cc`.
- Squash: on `sq_valid`, decrement the same way using the `sq_*` inputs.
- Net update per entry is +issue −retire −squash, applied in one step. Range of the delta is −2..+1; compute it in 3-bit signed arithmetic.
- Simultaneous inc/dec on the same entry nets to zero. The counter is unchanged and no error is raised.
- Overflow: if the result exceeds 3, hold at 3 and set `sb_error`.
- Underflow: if the result is below 0, hold at 0 and set `sb_error`.
- `sb_error` clears only on reset.
- WAW needs no check; ordering is in-order.
- A decode instruction may read and write the same register. Hazard evaluation uses pre-issue state, so self-dependence never stalls.

## Timing
- Reset (`reset_n` low, asynchronous): all counters 0, `busy`=0, `sb_error`=0. `dep_stall` becomes 0 because every `hot` bit is 0.
- Reset asserted mid-operation discards all tracking. The surrounding pipeline is reset in the same way.
- `dep_stall` and `busy`-derived hazard logic are combinational: zero-cycle latency from decode inputs and current state.
- Counter updates take effect on the next rising edge. An instruction issued at edge k makes `busy` visible from cycle k+1.
- `WB_BYPASS=0`: a reader is released in the cycle after its writer retires.
- `WB_BYPASS=1`: a reader is released in the same cycle its writer retires.
- `load_ex`=0 (mem stall) blocks issue. Counters change only by retire or squash during that cycle.

## Structure
- Add to `lc3b_types`:
  - `lc3b_sb_idx` (4-bit).
  - Constants `SB_CC_IDX = 8` and `SB_ENTRIES = 9`.
  - `lc3b_sb_vec` (9-bit).
- Sub-module `sb_counter`:
  - One saturating counter with signed delta input and an overflow/underflow flag output.
  - Instantiated 9×.
  - The top level does decode of inc/dec, hazard muxing, and the error OR.

## Test plan
- Reset, then decode ADD R1←R2,R3 with `load_ex`=1 → `dep_stall`=0; after the edge, `busy`=0x002.
- Issue ADD R1, then next cycle decode ADD R4←R1,R1 → `dep_stall`=1. It stays 1 until `wb_valid` with `wb_dr`=1:
  - `WB_BYPASS=1`: falls in that cycle.
  - `WB_BYPASS=0`: falls in the following cycle.
- Issue three writers to R5 back-to-back → `cnt[5]`=3 and `sb_error`=0. A fourth issue without a retire → count holds 3 and `sb_error`=1.
- ADD sets CC, then BR with `cc_used` → stall. Assert `sq_valid` with `sq_sets_cc`=1 → `busy[8]` clears on the next edge and the stall releases.
- Same cycle: issue writes R2 and WB retires R2 with `cnt[2]`=1 → `cnt[2]` stays 1 and `sb_error`=0.
- Retire R6 with `cnt[6]`=0 → `sb_error`=1. Then assert `reset_n`=0 asynchronously mid-cycle → all outputs 0 immediately.
